// File: rtl/testci_ci_initiator.sv
// Initiator for a Nios II style multicycle custom-instruction component.
// It takes one operand at a time from a valid/ready request port and returns the result or a timeout on a valid/ready response port.
module testci_ci_initiator #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic [DATA_W-1:0] req_data,
    output logic              req_ready,
    output logic              ci_clk_en,
    output logic              ci_start,
    output logic [DATA_W-1:0] ci_dataa,
    input  logic              ci_done,
    input  logic [DATA_W-1:0] ci_result,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_timeout,
    input  logic              rsp_ready,
    output logic              busy,
    output logic              err_spurious
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                req_ready_q, req_ready_d;
    logic                ci_clk_en_q, ci_clk_en_d;
    logic                ci_start_q, ci_start_d;
    logic [DATA_W-1:0]   ci_dataa_q, ci_dataa_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic                busy_q, busy_d;
    logic                err_spurious_q, err_spurious_d;
    logic                accept_s;

    // Next-state, datapath capture and sticky error logic.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ci_dataa_d     = ci_dataa_q;
        rsp_data_d     = rsp_data_q;
        rsp_timeout_d  = rsp_timeout_q;
        err_spurious_d = err_spurious_q;
        accept_s       = req_valid & req_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    ci_dataa_d = req_data;
                    cnt_d      = '0;
                    state_d    = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
                if (ci_done) begin
                    err_spurious_d = 1'b1;
                end else begin
                    err_spurious_d = err_spurious_q;
                end
            end
            ST_START: begin
                if (ci_done) begin
                    rsp_data_d    = ci_result;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A done on the last allowed cycle takes priority over the timeout.
                if (ci_done) begin
                    rsp_data_d    = ci_result;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d    = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
                if (ci_done) begin
                    err_spurious_d = 1'b1;
                end else begin
                    err_spurious_d = err_spurious_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs decoded from the upcoming state; req_ready trails IDLE entry by one cycle.
    always_comb begin
        req_ready_d = (state_q == ST_IDLE) && !accept_s;
        ci_start_d  = (state_d == ST_START);
        ci_clk_en_d = (state_d == ST_START) || (state_d == ST_WAIT);
        rsp_valid_d = (state_d == ST_RESP);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            req_ready_q    <= 1'b0;
            ci_clk_en_q    <= 1'b0;
            ci_start_q     <= 1'b0;
            ci_dataa_q     <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            rsp_timeout_q  <= 1'b0;
            busy_q         <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            req_ready_q    <= req_ready_d;
            ci_clk_en_q    <= ci_clk_en_d;
            ci_start_q     <= ci_start_d;
            ci_dataa_q     <= ci_dataa_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            rsp_timeout_q  <= rsp_timeout_d;
            busy_q         <= busy_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign ci_clk_en    = ci_clk_en_q;
    assign ci_start     = ci_start_q;
    assign ci_dataa     = ci_dataa_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_timeout  = rsp_timeout_q;
    assign busy         = busy_q;
    assign err_spurious = err_spurious_q;

endmodule

// File: tb/tb_testci_ci_initiator.sv
// Directed bench for testci_ci_initiator with TIMEOUT=8; the component is emulated by driving ci_done/ci_result per scenario.
module tb_testci_ci_initiator;

    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic [DW-1:0] req_data;
    logic          req_ready;
    logic          ci_clk_en;
    logic          ci_start;
    logic [DW-1:0] ci_dataa;
    logic          ci_done;
    logic [DW-1:0] ci_result;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_timeout;
    logic          rsp_ready;
    logic          busy;
    logic          err_spurious;

    int checks = 0;
    int errors = 0;

    testci_ci_initiator #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .ci_clk_en(ci_clk_en), .ci_start(ci_start), .ci_dataa(ci_dataa),
        .ci_done(ci_done), .ci_result(ci_result),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .rsp_ready(rsp_ready), .busy(busy), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request; ci_done is pulsed k cycles after the start cycle (k<0: never).
    // lat = cycles from the start cycle to the first rsp_valid cycle.
    task automatic run_txn(input logic [DW-1:0] data, input int k, input logic [DW-1:0] res,
                           output int lat, output int en_cnt, output int st_cnt);
        int w;
        w = 0;
        req_valid = 1'b1;
        req_data  = data;
        while (req_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_wait req_ready=%b required 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
        lat = 0; en_cnt = 0; st_cnt = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            if (ci_clk_en === 1'b1) en_cnt++;
            if (ci_start === 1'b1) st_cnt++;
            ci_done   = (lat == k);
            ci_result = (lat == k) ? res : 32'h0000_0000;
            tick();
            lat++;
        end
        ci_done = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #2;
        reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({req_ready, ci_start, ci_clk_en, rsp_valid, rsp_timeout, busy, err_spurious} !== 7'b0000000) begin
            errors++;
            $display("FAIL reset_flags got %b required 0000000",
                     {req_ready, ci_start, ci_clk_en, rsp_valid, rsp_timeout, busy, err_spurious});
        end
        checks++;
        if (ci_dataa !== 32'h0 || rsp_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data dataa=%h rsp_data=%h required 0", ci_dataa, rsp_data);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b required 1", req_ready);
        end
    endtask

    task automatic test_single();
        int lat, en, st;
        rsp_ready = 1'b1;
        run_txn(32'h0000_0005, 0, 32'h0000_000A, lat, en, st);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL single_latency got %0d required 1", lat); end
        checks++;
        if (rsp_data !== 32'h0000_000A) begin errors++; $display("FAIL single_data got %h required 0000000a", rsp_data); end
        checks++;
        if (rsp_timeout !== 1'b0 || ci_clk_en !== 1'b0) begin
            errors++;
            $display("FAIL single_flags timeout=%b clk_en=%b required 0 0", rsp_timeout, ci_clk_en);
        end
        checks++;
        if (ci_dataa !== 32'h0000_0005) begin errors++; $display("FAIL single_dataa got %h required 00000005", ci_dataa); end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_post valid=%b ready=%b busy=%b required 0 0 0", rsp_valid, req_ready, busy);
        end
        tick();
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL single_ready_again got %b required 1", req_ready); end
    endtask

    task automatic test_multicycle();
        int lat, en, st;
        rsp_ready = 1'b1;
        run_txn(32'h0000_1234, 5, 32'hDEAD_BEEF, lat, en, st);
        checks++;
        if (en !== 6 || st !== 1) begin
            errors++;
            $display("FAIL multi_enables clk_en_cycles=%0d start_cycles=%0d required 6 1", en, st);
        end
        checks++;
        if (lat !== 6) begin errors++; $display("FAIL multi_latency got %0d required 6", lat); end
        checks++;
        if (rsp_data !== 32'hDEAD_BEEF || rsp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL multi_data got %h/%b required deadbeef/0", rsp_data, rsp_timeout);
        end
        tick();
    endtask

    task automatic test_done_last_wait();
        int lat, en, st;
        rsp_ready = 1'b1;
        run_txn(32'h0000_0022, TO, 32'h0000_1234, lat, en, st);
        checks++;
        if (lat !== 9 || rsp_timeout !== 1'b0 || rsp_data !== 32'h0000_1234) begin
            errors++;
            $display("FAIL last_wait_done lat=%0d timeout=%b data=%h required 9 0 00001234", lat, rsp_timeout, rsp_data);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int lat, en, st;
        rsp_ready = 1'b0;
        run_txn(32'h0000_0077, 2, 32'hCAFE_0001, lat, en, st);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'hCAFE_0001 || ci_clk_en !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold cyc=%0d valid=%b data=%h clk_en=%b ready=%b required 1 cafe0001 0 0",
                         i, rsp_valid, rsp_data, ci_clk_en, req_ready);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release valid=%b busy=%b required 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] list [4];
        int acc_cyc [4];
        int cyc, na, nr;
        logic acc;
        list[0] = 32'h0000_0010; list[1] = 32'h0000_0020;
        list[2] = 32'h0000_0030; list[3] = 32'h0000_0040;
        cyc = 0; na = 0; nr = 0;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_data  = list[0];
        while (nr < 4 && cyc < 60) begin
            acc = req_valid & req_ready;
            if (rsp_valid === 1'b1) begin
                checks++;
                if (rsp_data !== list[nr] + 32'h0000_0100) begin
                    errors++;
                    $display("FAIL b2b_data idx=%0d got %h required %h", nr, rsp_data, list[nr] + 32'h0000_0100);
                end
                nr++;
            end
            ci_done   = ci_start;
            ci_result = ci_dataa + 32'h0000_0100;
            tick();
            cyc++;
            if (acc && na < 4) begin
                acc_cyc[na] = cyc - 1;
                na++;
                if (na < 4) req_data = list[na];
                else req_valid = 1'b0;
            end
        end
        ci_done = 1'b0;
        req_valid = 1'b0;
        checks++;
        if (nr !== 4 || na !== 4) begin
            errors++;
            $display("FAIL b2b_count responses=%0d accepts=%0d required 4 4", nr, na);
        end
        for (int i = 1; i < 4; i++) begin
            if (i < na) begin
                checks++;
                if (acc_cyc[i] - acc_cyc[i-1] !== 4) begin
                    errors++;
                    $display("FAIL b2b_spacing idx=%0d got %0d required 4", i, acc_cyc[i] - acc_cyc[i-1]);
                end
            end
        end
        checks++;
        if (err_spurious !== 1'b0) begin errors++; $display("FAIL b2b_no_spurious got %b required 0", err_spurious); end
        tick();
    endtask

    task automatic test_timeout();
        int lat, en, st;
        rsp_ready = 1'b0;
        run_txn(32'h0000_0011, -1, 32'h0, lat, en, st);
        checks++;
        if (lat !== TO + 1 || en !== TO + 1) begin
            errors++;
            $display("FAIL timeout_latency lat=%0d clk_en_cycles=%0d required 9 9", lat, en);
        end
        checks++;
        if (rsp_timeout !== 1'b1 || rsp_data !== 32'h0 || err_spurious !== 1'b0) begin
            errors++;
            $display("FAIL timeout_rsp timeout=%b data=%h err=%b required 1 0 0", rsp_timeout, rsp_data, err_spurious);
        end
        tick();
        tick();
        tick();
        ci_done   = 1'b1;
        ci_result = 32'hBAD0_BAD0;
        tick();
        ci_done = 1'b0;
        checks++;
        if (err_spurious !== 1'b1) begin errors++; $display("FAIL late_done_err got %b required 1", err_spurious); end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h0 || rsp_timeout !== 1'b1) begin
            errors++;
            $display("FAIL late_done_rsp valid=%b data=%h timeout=%b required 1 0 1", rsp_valid, rsp_data, rsp_timeout);
        end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || err_spurious !== 1'b1) begin
            errors++;
            $display("FAIL timeout_release valid=%b err=%b required 0 1", rsp_valid, err_spurious);
        end
    endtask

    task automatic test_reset_mid_wait();
        int lat, en, st, w;
        w = 0;
        req_valid = 1'b1;
        req_data  = 32'h0000_0033;
        while (req_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (ci_clk_en !== 1'b1 || ci_start !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_wait_state clk_en=%b start=%b busy=%b required 1 0 1", ci_clk_en, ci_start, busy);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, ci_start, ci_clk_en, rsp_valid, rsp_timeout, busy, err_spurious} !== 7'b0000000
            || ci_dataa !== 32'h0 || rsp_data !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_values flags=%b dataa=%h data=%h required 0",
                     {req_ready, ci_start, ci_clk_en, rsp_valid, rsp_timeout, busy, err_spurious}, ci_dataa, rsp_data);
        end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (req_ready !== 1'b1 || ci_start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_release ready=%b start=%b busy=%b required 1 0 0", req_ready, ci_start, busy);
        end
        rsp_ready = 1'b1;
        run_txn(32'h0000_0042, 0, 32'h0000_0099, lat, en, st);
        checks++;
        if (lat !== 1 || rsp_data !== 32'h0000_0099 || rsp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_after lat=%0d data=%h timeout=%b required 1 00000099 0", lat, rsp_data, rsp_timeout);
        end
        tick();
    endtask

    initial begin
        reset_n   = 1'b1;
        req_valid = 1'b0;
        req_data  = 32'h0;
        ci_done   = 1'b0;
        ci_result = 32'h0;
        rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_multicycle();
        test_done_last_wait();
        test_backpressure();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
